matrix_row_packer: RTL and testbench

Serial-to-parallel packer that sits directly upstream of `matrix_fill`. It accepts a stream of matrix elements, one per handshake, and assembles them in row-major order into the packed `A_rows` word that `matrix_fill` unpacks into a 2x4 matrix. It double-buffers one assembly register and one output register, so the stream keeps flowing while downstream stalls. It zero-pads and flushes a short final word when the stream marks its last element.

---
 rtl/matrix_row_packer_if.sv | 33 +++
 rtl/matrix_row_packer.sv | 175 +++++++++++++++++
 tb/tb_matrix_row_packer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/matrix_row_packer_if.sv
// matrix_row_packer_if
//   Element stream in, packed-word stream out, for matrix_row_packer.
//   Signals:
//     in_valid/in_data/in_last/in_ready : element handshake (producer -> packer)
//     out_valid/out_data/out_count/out_last/out_ready : packed word handshake
//                                         (packer -> matrix_fill)
//   Modports:
//     master : the environment side (drives elements, accepts words)
//     slave  : the packer side
interface matrix_row_packer_if #(
  parameter int ELEM_W = 4,
  parameter int N_ELEM = 8
);
  logic                     in_valid;
  logic [ELEM_W-1:0]        in_data;
  logic                     in_last;
  logic                     in_ready;
  logic                     out_valid;
  logic [ELEM_W*N_ELEM-1:0] out_data;
  logic [3:0]               out_count;
  logic                     out_last;
  logic                     out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last
  );
endinterface

// File: rtl/matrix_row_packer.sv
// matrix_row_packer
//   Packs a stream of ELEM_W-bit elements, row-major, into ELEM_W*N_ELEM-bit
//   words for matrix_fill. One assembly register plus one output register let
//   a full word wait in assembly while the previous word is stalled downstream.
//   A short final word (in_last) is zero-padded and flushed.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : matrix_row_packer_if.slave (element in, packed word out)
module matrix_row_packer #(
  parameter int ELEM_W = 4,
  parameter int N_ELEM = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  matrix_row_packer_if.slave bus
);
  localparam int WORD_W = ELEM_W * N_ELEM;
  localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic [0:0] {FILL = 1'b0, HOLD = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic              hold_last_q, hold_last_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [3:0]        out_count_q, out_count_d;
  logic              out_last_q, out_last_d;

  logic              in_ready_s;
  logic              accept_s;
  logic              complete_s;
  logic              slot_free_s;
  logic [3:0]        cnt_new_s;
  logic [WORD_W-1:0] asm_wr_s;

  // Acceptance, word completion and the assembly word with the new lane inserted
  always_comb begin
    accept_s    = bus.in_valid && in_ready_s;
    complete_s  = accept_s && ((idx_q == LAST_IDX) || bus.in_last);
    slot_free_s = !out_valid_q || bus.out_ready;
    cnt_new_s   = 4'(idx_q) + 4'd1;
    asm_wr_s    = asm_q;
    asm_wr_s[idx_q*ELEM_W +: ELEM_W] = bus.in_data;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (complete_s && !slot_free_s) begin
          state_d = HOLD;
        end else begin
          state_d = FILL;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = FILL;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // FSM output decode: the only input-side flow control, purely from state
  always_comb begin
    in_ready_s = 1'b1;
    case (state_q)
      FILL:    in_ready_s = 1'b1;
      HOLD:    in_ready_s = 1'b0;
      default: in_ready_s = 1'b1;
    endcase
  end

  // Datapath next-state: assembly lanes, held word metadata, output register
  always_comb begin
    idx_d       = idx_q;
    asm_d       = asm_q;
    hold_cnt_d  = hold_cnt_q;
    hold_last_d = hold_last_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    // A downstream transfer empties the slot unless a new word loads below.
    out_valid_d = out_valid_q && !bus.out_ready;
    case (state_q)
      FILL: begin
        if (accept_s) begin
          if (complete_s) begin
            idx_d = '0;
            if (slot_free_s) begin
              out_data_d  = asm_wr_s;
              out_count_d = cnt_new_s;
              out_last_d  = bus.in_last;
              out_valid_d = 1'b1;
              asm_d       = '0;
            end else begin
              // Park the finished word in assembly until the slot drains.
              asm_d       = asm_wr_s;
              hold_cnt_d  = cnt_new_s;
              hold_last_d = bus.in_last;
            end
          end else begin
            asm_d = asm_wr_s;
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_data_d  = asm_q;
          out_count_d = hold_cnt_q;
          out_last_d  = hold_last_q;
          out_valid_d = 1'b1;
          asm_d       = '0;
        end else begin
          asm_d = asm_q;
        end
      end
      default: begin
        idx_d = '0;
        asm_d = '0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      asm_q       <= '0;
      hold_cnt_q  <= 4'd0;
      hold_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= 4'd0;
      out_last_q  <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_last_q <= hold_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_matrix_row_packer.sv
// tb_matrix_row_packer
//   Directed checks of matrix_row_packer followed by a randomised stream
//   against a reference packing model. Inputs change on the falling edge;
//   outputs are read after the falling edge.
module tb_matrix_row_packer;
  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  matrix_row_packer_if #(.ELEM_W(4), .N_ELEM(8)) bus ();

  matrix_row_packer #(.ELEM_W(4), .N_ELEM(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state for the random phase
  logic [36:0] sb_q[$];
  logic [31:0] m_word = 32'd0;
  int          m_idx  = 0;
  logic        mon_en = 1'b0;
  int          words_seen = 0;
  logic [36:0] exp_w;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one element and return at the falling edge after it was accepted
  task automatic send(input logic [3:0] d, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_val("send_timeout", 64'd1, 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] d,
                           input logic [3:0] c, input logic l);
    check_val({tag, "_valid"}, 64'(bus.out_valid), 64'(v));
    check_val({tag, "_data"},  64'(bus.out_data),  64'(d));
    check_val({tag, "_count"}, 64'(bus.out_count), 64'(c));
    check_val({tag, "_last"},  64'(bus.out_last),  64'(l));
  endtask

  task automatic model_accept(input logic [3:0] d, input logic l);
    m_word[m_idx*4 +: 4] = d;
    if (m_idx == 7 || l) begin
      sb_q.push_back({m_word, 4'(m_idx + 1), l});
      m_word = 32'd0;
      m_idx  = 0;
    end else begin
      m_idx++;
    end
  endtask

  // Scoreboard: compare every downstream transfer against the model
  always @(negedge clk) begin
    #1;
    if (mon_en && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check_val("sb_extra_word", 64'd1, 64'd0);
      end else begin
        exp_w = sb_q.pop_front();
        check_val("sb_word", 64'({bus.out_data, bus.out_count, bus.out_last}), 64'(exp_w));
        words_seen++;
      end
    end
  end

  initial begin
    int sent;
    int cyc;
    logic took;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    check_out("rst", 1'b0, 32'h0, 4'd0, 1'b0);
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full word, downstream always ready
    for (int i = 1; i <= 8; i++) begin
      send(4'(i), 1'b0);
      if (i == 7) check_val("full_pre_valid", 64'(bus.out_valid), 64'd0);
    end
    check_out("full", 1'b1, 32'h87654321, 4'd8, 1'b0);
    @(negedge clk);
    check_val("full_one_cycle", 64'(bus.out_valid), 64'd0);

    // Short word closed by in_last, then a fresh word from index 0
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    send(4'hC, 1'b1);
    check_out("short", 1'b1, 32'h00000CBA, 4'd3, 1'b1);
    send(4'h5, 1'b1);
    check_out("short_next", 1'b1, 32'h00000005, 4'd1, 1'b1);
    @(negedge clk);

    // Downstream stalled across two words
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      send(4'(i), 1'b0);
      if (i == 12) check_val("stall_stable", 64'(bus.out_data), 64'h87654321);
    end
    check_out("stall_hold", 1'b1, 32'h87654321, 4'd8, 1'b0);
    check_val("stall_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_out("release", 1'b1, 32'h0FEDCBA9, 4'd8, 1'b0);
    check_val("release_in_ready", 64'(bus.in_ready), 64'd1);

    // Offers during HOLD must not be captured
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
    check_val("hold2_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 4'(4'hF - i);
      @(negedge clk);
      check_val("hold2_blocked", 64'(bus.in_ready), 64'd0);
    end
    bus.in_data   = 4'h4;
    bus.in_last   = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_out("hold2_release", 1'b1, 32'h87654321, 4'd8, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_out("after_hold", 1'b1, 32'h00000004, 4'd1, 1'b1);
    @(negedge clk);

    // Reset in the middle of a word with a stalled word presented
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(4'h9, 1'b0);
    for (int i = 0; i < 5; i++) send(4'h9, 1'b0);
    check_val("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("mid_rst", 1'b0, 32'h0, 4'd0, 1'b0);
    check_val("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
    check_out("post_rst", 1'b1, 32'h87654321, 4'd8, 1'b0);
    @(negedge clk);
    @(negedge clk);

    // Random stream against the reference model
    mon_en = 1'b1;
    sent = 0;
    cyc  = 0;
    took = 1'b0;
    while (sent < 10000 && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid || took) begin
        if ($urandom_range(0, 3) != 0) begin
          bus.in_valid = 1'b1;
          bus.in_data  = 4'($urandom_range(0, 15));
          bus.in_last  = (sent == 9999) || ($urandom_range(0, 7) == 0);
        end else begin
          bus.in_valid = 1'b0;
          bus.in_last  = 1'b0;
        end
      end
      #1;
      took = bus.in_valid && bus.in_ready;
      if (took) begin
        model_accept(bus.in_data, bus.in_last);
        sent++;
      end
    end
    check_val("rand_all_sent", 64'(sent), 64'd10000);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    check_val("sb_drained", 64'(sb_q.size()), 64'd0);
    check_val("sb_words_seen", 64'(words_seen > 1000), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
